design_1: RTL and testbench



---
 rtl/sched_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/design_1.sv | 123 ++++++++++++
 tb/tb_design_1.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared types and default sizing for the multi-thread issue scheduler.
package sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_NUM_THREADS = 4;
    localparam int DEF_ITERS       = 8;
    localparam int DEF_ISSUE_LAT   = 3;
    localparam int DEF_TID_W       = $clog2(DEF_NUM_THREADS);

    typedef logic [DEF_TID_W-1:0] tid_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first ready thread after the last grant, wrapping.
module rr_arbiter #(
    parameter int NUM_THREADS = 4,
    parameter int TID_W       = 2
) (
    input  logic [NUM_THREADS-1:0] ready_i,
    input  logic [TID_W-1:0]       last_i,
    output logic                   grant_valid_o,
    output logic [TID_W-1:0]       grant_id_o
);

    always_comb begin
        int idx;
        idx           = 0;
        grant_valid_o = 1'b0;
        grant_id_o    = '0;
        for (int k = 1; k <= NUM_THREADS; k++) begin
            idx = int'(last_i) + k;
            if (idx >= NUM_THREADS) idx = idx - NUM_THREADS;
            if (!grant_valid_o && ready_i[idx]) begin
                grant_valid_o = 1'b1;
                grant_id_o    = TID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/design_1.sv
// Multi-thread issue scheduler: launches NUM_THREADS threads, issues each ITERS
// times through a round-robin arbiter, blocking a thread ISSUE_LAT cycles per issue.
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | arbitrating and issuing ready threads
// DONE  | all threads exhausted; start relaunches
module design_1
    import sched_pkg::*;
#(
    parameter int NUM_THREADS = DEF_NUM_THREADS,
    parameter int ITERS       = DEF_ITERS,
    parameter int ISSUE_LAT   = DEF_ISSUE_LAT,
    parameter int TID_W       = $clog2(NUM_THREADS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             issue_valid,
    output logic [TID_W-1:0] issue_tid,
    output logic [15:0]      issue_count
);

    state_t                 state_q, state_d;
    logic [TID_W-1:0]       rr_q;
    logic [15:0]            count_q;
    logic [NUM_THREADS-1:0] ready;
    logic [7:0]             remaining [NUM_THREADS];
    logic                   grant_valid;
    logic [TID_W-1:0]       grant_id;
    logic                   launch;
    logic                   issue;
    logic                   last_issue;

    assign launch = start && (state_q != RUN);
    assign issue  = (state_q == RUN) && grant_valid;

    for (genvar i = 0; i < NUM_THREADS; i++) begin : g_thr
        logic [7:0] rem_q;
        logic [3:0] blk_q;
        logic       sel;

        assign sel          = issue && (grant_id == TID_W'(i));
        assign ready[i]     = (rem_q != 8'd0) && (blk_q == 4'd0);
        assign remaining[i] = rem_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rem_q <= 8'd0;
                blk_q <= 4'd0;
            end else if (launch) begin
                rem_q <= 8'(ITERS);
                blk_q <= 4'd0;
            end else if (state_q == RUN) begin
                if (sel) begin
                    rem_q <= rem_q - 8'd1;
                    blk_q <= 4'(ISSUE_LAT);
                end else if (blk_q != 4'd0) begin
                    blk_q <= blk_q - 4'd1;
                end
            end
        end
    end

    rr_arbiter #(
        .NUM_THREADS (NUM_THREADS),
        .TID_W       (TID_W)
    ) u_arb (
        .ready_i       (ready),
        .last_i        (rr_q),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id)
    );

    // True when this cycle's issue retires the final outstanding iteration.
    always_comb begin
        last_issue = issue;
        for (int i = 0; i < NUM_THREADS; i++) begin
            if (!((remaining[i] == 8'd0) ||
                  ((grant_id == TID_W'(i)) && (remaining[i] == 8'd1))))
                last_issue = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_q    <= TID_W'(NUM_THREADS - 1);
            count_q <= 16'd0;
        end else if (launch) begin
            rr_q    <= TID_W'(NUM_THREADS - 1);
            count_q <= 16'd0;
        end else if (issue) begin
            rr_q <= grant_id;
            if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)      state_d = RUN;
            RUN:     if (last_issue) state_d = DONE;
            DONE:    if (start)      state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q == RUN);
        done        = (state_q == DONE);
        issue_valid = issue;
        issue_tid   = issue ? grant_id : '0;
        issue_count = count_q;
    end

endmodule

// File: tb/tb_design_1.sv
// Scoreboard bench: three scheduler configurations, expectations queued per instance.
module tb_design_1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start_a, start_b, start_c;

    logic busy_a, done_a, valid_a; logic [1:0] tid_a; logic [15:0] cnt_a;
    logic busy_b, done_b, valid_b; logic [1:0] tid_b; logic [15:0] cnt_b;
    logic busy_c, done_c, valid_c; logic [0:0] tid_c; logic [15:0] cnt_c;

    design_1 u_a (
        .clk(clk), .reset(reset), .start(start_a),
        .busy(busy_a), .done(done_a), .issue_valid(valid_a),
        .issue_tid(tid_a), .issue_count(cnt_a));

    design_1 #(.NUM_THREADS(4), .ITERS(2), .ISSUE_LAT(7)) u_b (
        .clk(clk), .reset(reset), .start(start_b),
        .busy(busy_b), .done(done_b), .issue_valid(valid_b),
        .issue_tid(tid_b), .issue_count(cnt_b));

    design_1 #(.NUM_THREADS(2), .ITERS(1), .ISSUE_LAT(0)) u_c (
        .clk(clk), .reset(reset), .start(start_c),
        .busy(busy_c), .done(done_c), .issue_valid(valid_c),
        .issue_tid(tid_c), .issue_count(cnt_c));

    logic busy [3], done [3], valid [3];
    int   tid  [3];
    int   cnt  [3];

    always_comb begin
        busy[0] = busy_a;  busy[1] = busy_b;  busy[2] = busy_c;
        done[0] = done_a;  done[1] = done_b;  done[2] = done_c;
        valid[0] = valid_a; valid[1] = valid_b; valid[2] = valid_c;
        tid[0] = int'(tid_a); tid[1] = int'(tid_b); tid[2] = int'(tid_c);
        cnt[0] = int'(cnt_a); cnt[1] = int'(cnt_b); cnt[2] = int'(cnt_c);
    end

    typedef struct {
        int cyc;
        int tid;
        int cnt;
    } exp_t;

    exp_t q [3][$];
    int   total = 0;
    int   bad   = 0;
    int   cyc    [3] = '{0, 0, 0};
    logic busy_p [3] = '{1'b0, 1'b0, 1'b0};

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int j, input int c, input int t, input int n);
        exp_t e;
        e.cyc = c; e.tid = t; e.cnt = n;
        q[j].push_back(e);
    endtask

    // Monitor: samples on the falling edge, pops an expectation per issue.
    always @(negedge clk) begin
        for (int j = 0; j < 3; j++) begin
            exp_t e;
            if (busy[j] && !busy_p[j]) cyc[j] = 0;
            if (valid[j]) begin
                check("valid_only_in_run", int'(busy[j]), 1);
                if (q[j].size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_issue: inst %0d tid %0d got issue, required none", j, tid[j]);
                end else begin
                    e = q[j].pop_front();
                    check("issue_tid", tid[j], e.tid);
                    check("issue_cycle", cyc[j], e.cyc);
                    check("issue_count_at_issue", cnt[j], e.cnt);
                end
            end else if (tid[j] != 0) begin
                check("tid_zero_when_idle", tid[j], 0);
            end
            if (busy[j]) cyc[j]++;
            busy_p[j] = busy[j];
        end
    end

    task automatic set_start(input int j, input logic v);
        case (j)
            0: start_a = v;
            1: start_b = v;
            default: start_c = v;
        endcase
    endtask

    task automatic pulse(input int j);
        @(negedge clk); set_start(j, 1'b1);
        @(negedge clk); set_start(j, 1'b0);
    endtask

    task automatic wait_done(input int j, input int exp_cnt, input int exp_cyc);
        int n;
        n = 0;
        while (!done[j] && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", int'(done[j]), 1);
        check("busy_after_run", int'(busy[j]), 0);
        check("final_issue_count", cnt[j], exp_cnt);
        check("run_cycles", cyc[j], exp_cyc);
        check("queue_drained", q[j].size(), 0);
    endtask

    initial begin
        reset = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        #12;
        for (int j = 0; j < 3; j++) begin
            check("rst_busy", int'(busy[j]), 0);
            check("rst_done", int'(done[j]), 0);
            check("rst_valid", int'(valid[j]), 0);
            check("rst_count", cnt[j], 0);
        end
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);

        // Default config: 0,1,2,3 round robin, no bubbles.
        for (int k = 0; k < 32; k++) push(0, k, k % 4, k);
        pulse(0);
        wait_done(0, 32, 32);

        // Relaunch from DONE with start held high into the run.
        for (int k = 0; k < 32; k++) push(0, k, k % 4, k);
        @(negedge clk); start_a = 1'b1;
        @(negedge clk);
        check("relaunch_done_low", int'(done_a), 0);
        check("relaunch_busy_high", int'(busy_a), 1);
        repeat (18) @(negedge clk);
        start_a = 1'b0;
        wait_done(0, 32, 32);

        // Asynchronous reset mid-run.
        for (int k = 0; k < 32; k++) push(0, k, k % 4, k);
        pulse(0);
        for (int n = 0; n < 40 && q[0].size() > 22; n++) @(negedge clk);
        check("midrun_busy_before_reset", int'(busy_a), 1);
        #2 reset = 1'b0;
        #1;
        check("midrun_rst_busy", int'(busy_a), 0);
        check("midrun_rst_valid", int'(valid_a), 0);
        check("midrun_rst_count", cnt_a, 0);
        check("midrun_rst_done", int'(done_a), 0);
        q[0].delete();
        #3 reset = 1'b1;
        repeat (5) @(negedge clk);
        check("after_abort_idle_busy", int'(busy_a), 0);
        check("after_abort_no_done", int'(done_a), 0);

        // Long latency: four bubbles between rounds.
        push(1, 0, 0, 0);  push(1, 1, 1, 1);  push(1, 2, 2, 2);  push(1, 3, 3, 3);
        push(1, 8, 0, 4);  push(1, 9, 1, 5);  push(1, 10, 2, 6); push(1, 11, 3, 7);
        pulse(1);
        wait_done(1, 8, 12);

        // Zero latency, two threads, single iteration.
        push(2, 0, 0, 0);
        push(2, 1, 1, 1);
        pulse(2);
        wait_done(2, 2, 2);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
